gate_dot_mac: RTL and testbench

- Time-multiplexed fixed-point dot-product unit for LSTM gate pre-activations: out = sum(W[i]*V[i]) + b over a streamed vector of any length 1..MAX_LEN.
- Generalises the two-term combinational multiply-add to N terms.
- Accumulates at full precision and shifts once at the end.
- One instance per gate (i, f, g, o); consumes concatenated {x, h} elements with matching weights, one element per cycle.

---
 rtl/lstm_fxp_pkg.sv | 21 ++
 rtl/fxp_narrow.sv | 50 +++++
 rtl/gate_dot_mac.sv | 98 +++++++++
 tb/tb_gate_dot_mac.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lstm_fxp_pkg.sv
// Shared fixed-point definitions for the LSTM datapath: default formats,
// the MAC control states and representable-range helpers.
package lstm_fxp_pkg;

    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_FRACT_WIDTH = 8;

    typedef enum logic {
        ACCUM = 1'b0,
        OUT   = 1'b1
    } mac_state_t;

    function automatic longint fxp_max(input int width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    function automatic longint fxp_min(input int width);
        return -(64'sd1 <<< (width - 1));
    endfunction

endpackage

// File: rtl/fxp_narrow.sv
// Narrows a full-precision accumulator to the DATA_WIDTH result format.
// GATE_DOT_MAC_SAT_EN selects clamping with a sat flag; otherwise the result wraps.
module fxp_narrow
    import lstm_fxp_pkg::*;
#(
    parameter int IN_W        = 39,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int FRACT_WIDTH = DEF_FRACT_WIDTH
) (
    input  logic [IN_W-1:0]       acc,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  sat
);

`ifdef GATE_DOT_MAC_SAT_EN
    localparam logic signed [IN_W-1:0] MAX_V = IN_W'(fxp_max(DATA_WIDTH));
    localparam logic signed [IN_W-1:0] MIN_V = IN_W'(fxp_min(DATA_WIDTH));

    // Floor shift first, then clamp against the representable range.
    function automatic logic [DATA_WIDTH-1:0] narrow_data(input logic signed [IN_W-1:0] a);
        logic signed [IN_W-1:0] r;
        r = a >>> FRACT_WIDTH;
        if (r > MAX_V) begin
            return MAX_V[DATA_WIDTH-1:0];
        end else if (r < MIN_V) begin
            return MIN_V[DATA_WIDTH-1:0];
        end
        return r[DATA_WIDTH-1:0];
    endfunction

    function automatic logic narrow_sat(input logic signed [IN_W-1:0] a);
        logic signed [IN_W-1:0] r;
        r = a >>> FRACT_WIDTH;
        return (r > MAX_V) || (r < MIN_V);
    endfunction

    assign data = narrow_data($signed(acc));
    assign sat  = narrow_sat($signed(acc));
`else
    function automatic logic [DATA_WIDTH-1:0] narrow_data(input logic signed [IN_W-1:0] a);
        logic signed [IN_W-1:0] r;
        r = a >>> FRACT_WIDTH;
        return r[DATA_WIDTH-1:0];
    endfunction

    assign data = narrow_data($signed(acc));
    assign sat  = 1'b0;
`endif

endmodule

// File: rtl/gate_dot_mac.sv
// Streaming fixed-point dot product with bias for one LSTM gate pre-activation.
// Build with GATE_DOT_MAC_SAT_EN to clamp out-of-range results instead of wrapping.
module gate_dot_mac
    import lstm_fxp_pkg::*;
#(
    parameter  int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter  int FRACT_WIDTH = DEF_FRACT_WIDTH,
    parameter  int MAX_LEN     = 64,
    localparam int CNT_W       = $clog2(MAX_LEN + 1),
    localparam int ACC_W       = 2 * DATA_WIDTH + $clog2(MAX_LEN) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_x,
    input  logic [DATA_WIDTH-1:0] in_w,
    input  logic                  in_last,
    input  logic [DATA_WIDTH-1:0] in_bias,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]      out_count,
    output logic                  out_len_err,
    output logic                  out_sat
);

    mac_state_t                  state_p0;
    logic signed [ACC_W-1:0]     acc_p0;
    logic [CNT_W-1:0]            count_p0;

    logic signed [2*DATA_WIDTH-1:0] product;
    logic signed [ACC_W-1:0]        bias_term;
    logic signed [ACC_W-1:0]        acc_next;
    logic [CNT_W-1:0]               count_next;
    logic                           vec_end;
    logic [DATA_WIDTH-1:0]          narrow_data;
    logic                           narrow_sat;

    assign in_ready  = (state_p0 == ACCUM);
    assign out_valid = (state_p0 == OUT);

    // Stage p0: full-precision multiply-accumulate; the bias enters on the first beat
    assign product    = (2*DATA_WIDTH)'($signed(in_w)) * (2*DATA_WIDTH)'($signed(in_x));
    assign bias_term  = ACC_W'($signed(in_bias)) <<< FRACT_WIDTH;
    assign acc_next   = (count_p0 == '0) ? ACC_W'(product) + bias_term
                                         : acc_p0 + ACC_W'(product);
    assign count_next = count_p0 + CNT_W'(1);
    assign vec_end    = in_last || (count_next == CNT_W'(MAX_LEN));

    fxp_narrow #(
        .IN_W        (ACC_W),
        .DATA_WIDTH  (DATA_WIDTH),
        .FRACT_WIDTH (FRACT_WIDTH)
    ) u_narrow (
        .acc  (acc_next),
        .data (narrow_data),
        .sat  (narrow_sat)
    );

    // Stage p1: result register loaded on the closing beat and held until consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0    <= ACCUM;
            acc_p0      <= '0;
            count_p0    <= '0;
            out_data    <= '0;
            out_count   <= '0;
            out_len_err <= 1'b0;
            out_sat     <= 1'b0;
        end else begin
            case (state_p0)
                ACCUM: begin
                    if (in_valid) begin
                        acc_p0   <= acc_next;
                        count_p0 <= count_next;
                        if (vec_end) begin
                            state_p0    <= OUT;
                            out_data    <= narrow_data;
                            out_count   <= count_next;
                            out_len_err <= !in_last;
                            out_sat     <= narrow_sat;
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state_p0 <= ACCUM;
                        acc_p0   <= '0;
                        count_p0 <= '0;
                    end
                end
                default: state_p0 <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_dot_mac.sv
// Scoreboard bench for gate_dot_mac: arithmetic reference model feeds an
// expectation queue, a negedge monitor compares every presented result.
module tb_gate_dot_mac;

    localparam int DW = 16;
    localparam int FW = 8;
    localparam int ML = 4;
    localparam int CW = $clog2(ML + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_x = '0;
    logic [DW-1:0] in_w = '0;
    logic          in_last = 1'b0;
    logic [DW-1:0] in_bias = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_count;
    logic          out_len_err;
    logic          out_sat;

    gate_dot_mac #(
        .DATA_WIDTH  (DW),
        .FRACT_WIDTH (FW),
        .MAX_LEN     (ML)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_x        (in_x),
        .in_w        (in_w),
        .in_last     (in_last),
        .in_bias     (in_bias),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_count   (out_count),
        .out_len_err (out_len_err),
        .out_sat     (out_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [CW-1:0] count;
        logic          len_err;
        logic          sat;
    } exp_t;

    exp_t   exp_q[$];
    int     lat_q[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     ready_mode = 2;
    longint msum = 0;
    int     mcnt = 0;
    bit     fresh = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = ($urandom_range(0, 3) != 0);
            1:       out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: sum of products plus bias scaled to the product format, floor-shifted once.
    task automatic model_beat(input logic [DW-1:0] x, input logic [DW-1:0] w,
                              input logic [DW-1:0] b, input logic last);
        exp_t   e;
        longint r;
        if (mcnt == 0) msum = longint'($signed(b)) * (64'sd1 <<< FW);
        msum += longint'($signed(w)) * longint'($signed(x));
        mcnt++;
        if (last || mcnt == ML) begin
            r = msum >>> FW;
            e.count   = CW'(mcnt);
            e.len_err = !last;
`ifdef GATE_DOT_MAC_SAT_EN
            if (r > (64'sd1 <<< (DW - 1)) - 1) begin
                e.data = {1'b0, {(DW-1){1'b1}}};
                e.sat  = 1'b1;
            end else if (r < -(64'sd1 <<< (DW - 1))) begin
                e.data = {1'b1, {(DW-1){1'b0}}};
                e.sat  = 1'b1;
            end else begin
                e.data = r[DW-1:0];
                e.sat  = 1'b0;
            end
`else
            e.data = r[DW-1:0];
            e.sat  = 1'b0;
`endif
            exp_q.push_back(e);
            lat_q.push_back(cyc);
            mcnt = 0;
        end
    endtask

    task automatic send(input logic [DW-1:0] x, input logic [DW-1:0] w,
                        input logic [DW-1:0] b, input logic last);
        bit done  = 1'b0;
        int guard = 0;
        while (!done) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            in_x     = x;
            in_w     = w;
            in_bias  = b;
            in_last  = last;
            @(negedge clk);
            if (in_ready) begin
                model_beat(x, w, b, last);
                done = 1'b1;
            end else if (++guard > 300) begin
                chk("beat_accept_timeout", 0, 1);
                done = 1'b1;
            end
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'($urandom_range(0, 1));
        in_x     = DW'($urandom);
    endtask

    task automatic drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 500) begin
            @(posedge clk);
            g++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    task automatic check_reset();
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_len_err", out_len_err, 0);
        chk("rst_sat", out_sat, 0);
    endtask

    function automatic logic [DW-1:0] rand_operand();
        logic [DW-1:0] v;
        if ($urandom_range(0, 1) == 1) begin
            v = DW'($urandom);
        end else begin
            v = DW'($urandom_range(0, 1023));
            if ($urandom_range(0, 1) == 1) v = -v;
        end
        return v;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            fresh = 1'b1;
        end else begin
            chk("in_ready_vs_out_valid", in_ready, !out_valid);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    if (fresh) begin
                        chk("latency_cycles", cyc, lat_q[0] + 1);
                        void'(lat_q.pop_front());
                        fresh = 1'b0;
                    end
                    chk("out_data", out_data, exp_q[0].data);
                    chk("out_count", out_count, exp_q[0].count);
                    chk("out_len_err", out_len_err, exp_q[0].len_err);
                    chk("out_sat", out_sat, exp_q[0].sat);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        fresh = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int len;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset();

        ready_mode = 2;
        send(16'h0100, 16'h0080, 16'h0100, 1'b0);
        send(16'h0200, 16'h0040, 16'h0100, 1'b1);
        idle();
        drain();

        send(16'hFFFF, 16'h0080, 16'h0000, 1'b1);
        idle();
        drain();

        // Consumer stalls while the next beat is already offered.
        ready_mode = 1;
        send(16'h0300, 16'h0100, 16'h0010, 1'b1);
        fork
            send(16'h0200, 16'h0100, 16'h0000, 1'b1);
            begin
                repeat (6) @(posedge clk);
                ready_mode = 2;
            end
        join
        idle();
        drain();

        for (int i = 0; i < 4; i++) send(16'h7F00, 16'h0100, 16'h0000, 1'(i == 3));
        idle();
        drain();

        for (int i = 0; i < 4; i++) send(16'h8000, 16'h0100, 16'h0000, 1'(i == 3));
        idle();
        drain();

        for (int i = 0; i < 6; i++) send(DW'(16'h0100 + i), 16'h0100, 16'h0020, 1'b0);
        send(16'h0100, 16'h0100, 16'h0000, 1'b1);
        idle();
        drain();

        send(16'h1234, 16'h0200, 16'h0040, 1'b0);
        send(16'h0F00, 16'h0300, 16'h0040, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mcnt = 0;
        check_reset();
        send(16'h0100, 16'h0100, 16'h0000, 1'b1);
        idle();
        drain();

        ready_mode = 0;
        for (int v = 0; v < 150; v++) begin
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 4) == 0) idle();
                send(rand_operand(), rand_operand(), rand_operand(), 1'(i == len - 1));
            end
        end
        idle();
        ready_mode = 2;
        drain();
        chk("latency_queue_empty", lat_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
